gpio_mulpop: RTL and testbench



---
 rtl/gpio_mulpop_pkg.sv | 31 +++
 rtl/gpio_mulpop_engine.sv | 116 +++++++++++
 rtl/gpio_mulpop.sv | 157 +++++++++++++++
 tb/tb_gpio_mulpop.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_mulpop_pkg.sv
// Shared definitions for the gpio_mulpop coprocessor: register offsets,
// status codes, engine state encoding and the ones-count width helper.
package gpio_mulpop_pkg;

  localparam logic [15:0] OFF_A1   = 16'h0000;
  localparam logic [15:0] OFF_A2   = 16'h0008;
  localparam logic [15:0] OFF_W    = 16'h0010;
  localparam logic [15:0] OFF_L    = 16'h0018;
  localparam logic [15:0] OFF_CTRL = 16'h0020;
  localparam logic [15:0] OFF_GPIN = 16'h0028;

  typedef enum logic [1:0] {
    STAT_IDLE     = 2'b00,
    STAT_BUSY     = 2'b01,
    STAT_DONE     = 2'b10,
    STAT_DONE_OVF = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MULT = 2'b01,
    POP  = 2'b10,
    DONE = 2'b11
  } state_e;

  // Width needed to hold a count of 0..resW ones.
  function automatic int onesWidth(input int resW);
    return $clog2(resW + 1);
  endfunction

endpackage

// File: rtl/gpio_mulpop_engine.sv
// Serial shift-add multiplier followed by a bit-serial popcount of the
// truncated product; one multiplier bit or one result bit per cycle.
module gpio_mulpop_engine
  import gpio_mulpop_pkg::*;
#(
  parameter int OP_W  = 24,
  parameter int RES_W = 32,
  localparam int L_W  = onesWidth(RES_W)
) (
  input  logic             i_clk,
  input  logic             i_nReset,
  input  logic             i_start,
  input  logic [OP_W-1:0]  i_opA,
  input  logic [OP_W-1:0]  i_opB,
  output logic             o_busy,
  output logic             o_finish,
  output logic [RES_W-1:0] o_result,
  output logic [L_W-1:0]   o_ones,
  output logic             o_overflow
);

  localparam int PROD_W  = 2 * OP_W;
  localparam int EXT_W   = (RES_W > PROD_W) ? RES_W : PROD_W;
  localparam int CYC_MAX = (OP_W > RES_W) ? OP_W : RES_W;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  state_e             r_state;
  logic [CYC_W-1:0]   r_cycle;
  logic [PROD_W-1:0]  r_acc;
  logic [PROD_W-1:0]  r_mcand;
  logic [OP_W-1:0]    r_mplier;
  logic [RES_W-1:0]   r_popShift;
  logic [RES_W-1:0]   r_result;
  logic [L_W-1:0]     r_ones;
  logic               r_overflow;

  logic [PROD_W-1:0]  w_accNext;
  logic [EXT_W-1:0]   w_accExt;
  logic [RES_W-1:0]   w_resultNext;
  logic               w_ovfNext;
  logic               w_lastMult;
  logic               w_lastPop;

  // The final accumulator value is consumed on the same edge it is formed,
  // so truncation and overflow are taken from the next-state value.
  assign w_accNext    = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  assign w_accExt     = EXT_W'(w_accNext);
  assign w_resultNext = w_accExt[RES_W-1:0];
  assign w_ovfNext    = |(w_accExt >> RES_W);

  assign w_lastMult = (r_cycle == CYC_W'(OP_W - 1));
  assign w_lastPop  = (r_cycle == CYC_W'(RES_W - 1));

  assign o_busy     = (r_state != IDLE);
  assign o_finish   = (r_state == POP) && w_lastPop;
  assign o_result   = r_result;
  assign o_ones     = r_ones;
  assign o_overflow = r_overflow;

  always_ff @(posedge i_clk or negedge i_nReset) begin
    if (!i_nReset) begin
      r_state    <= IDLE;
      r_cycle    <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_popShift <= '0;
      r_result   <= '0;
      r_ones     <= '0;
      r_overflow <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state    <= MULT;
            r_cycle    <= '0;
            r_acc      <= '0;
            r_mcand    <= PROD_W'(i_opA);
            r_mplier   <= i_opB;
            r_result   <= '0;
            r_ones     <= '0;
            r_overflow <= 1'b0;
          end
        end
        MULT: begin
          r_acc    <= w_accNext;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          if (w_lastMult) begin
            r_state    <= POP;
            r_cycle    <= '0;
            r_result   <= w_resultNext;
            r_popShift <= w_resultNext;
            r_overflow <= w_ovfNext;
          end else begin
            r_cycle <= r_cycle + CYC_W'(1);
          end
        end
        POP: begin
          r_ones     <= r_ones + L_W'(r_popShift[0]);
          r_popShift <= r_popShift >> 1;
          if (w_lastPop) begin
            r_state <= DONE;
            r_cycle <= '0;
          end else begin
            r_cycle <= r_cycle + CYC_W'(1);
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/gpio_mulpop.sv
// Bus-mapped multiply/popcount coprocessor: register window decode, status
// and sticky error tracking, completed-operation counter and gpio_in latch.
module gpio_mulpop
  import gpio_mulpop_pkg::*;
#(
  parameter int          OP_W      = 24,
  parameter int          RES_W     = 32,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] BASE_ADDR = 16'h0380
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic [15:0] saddress,
  input  logic        srd,
  input  logic        swr,
  input  logic [31:0] sdata_in,
  output logic [31:0] sdata_out,
  input  logic [31:0] gpio_in,
  input  logic        gpio_latch,
  output logic [31:0] gpio_in_s_insp,
  output logic [31:0] gpio_out
);

  localparam int L_W = onesWidth(RES_W);

  logic             r_srdPrev;
  logic             r_swrPrev;
  logic             r_latchPrev;
  logic [OP_W-1:0]  r_a1;
  logic [OP_W-1:0]  r_a2;
  status_e          r_status;
  logic             r_err;
  logic [CNT_W-1:0] r_opCount;
  logic [31:0]      r_sdataOut;
  logic [31:0]      r_gpinLatched;

  logic             w_rdEdge;
  logic             w_wrEdge;
  logic             w_latchEdge;
  logic [15:0]      w_offset;
  logic             w_wrA1;
  logic             w_wrA2;
  logic             w_wrCtrl;
  logic             w_rdStatus;
  logic             w_busy;
  logic             w_busyWrite;
  logic             w_start;
  logic             w_finish;
  logic             w_overflow;
  logic [RES_W-1:0] w_result;
  logic [L_W-1:0]   w_ones;
  logic             w_resultValid;
  logic [31:0]      w_readData;

  // Subtraction is a bijection mod 2^16, so each offset maps to exactly one
  // address and no aliasing can occur outside the window.
  assign w_offset    = saddress - BASE_ADDR;
  assign w_rdEdge    = srd & ~r_srdPrev;
  assign w_wrEdge    = swr & ~r_swrPrev;
  assign w_latchEdge = gpio_latch & ~r_latchPrev;

  assign w_wrA1      = w_wrEdge && (w_offset == OFF_A1);
  assign w_wrA2      = w_wrEdge && (w_offset == OFF_A2);
  assign w_wrCtrl    = w_wrEdge && (w_offset == OFF_CTRL);
  assign w_rdStatus  = w_rdEdge && (w_offset == OFF_CTRL);
  assign w_busyWrite = w_busy && (w_wrA1 || w_wrA2 || w_wrCtrl);
  assign w_start     = w_wrCtrl && !w_busy;

  assign w_resultValid = r_status[1];

  gpio_mulpop_engine #(
    .OP_W  (OP_W),
    .RES_W (RES_W)
  ) u_engine (
    .i_clk      (clk),
    .i_nReset   (n_reset),
    .i_start    (w_start),
    .i_opA      (r_a1),
    .i_opB      (r_a2),
    .o_busy     (w_busy),
    .o_finish   (w_finish),
    .o_result   (w_result),
    .o_ones     (w_ones),
    .o_overflow (w_overflow)
  );

  always_comb begin
    w_readData = '0;
    case (w_offset)
      OFF_W:    if (w_resultValid) w_readData = 32'(w_result);
      OFF_L:    if (w_resultValid) w_readData = 32'(w_ones);
      OFF_CTRL: w_readData = {29'b0, r_err, r_status};
      OFF_GPIN: w_readData = r_gpinLatched;
      default:  w_readData = '0;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_srdPrev   <= 1'b0;
      r_swrPrev   <= 1'b0;
      r_latchPrev <= 1'b0;
    end else begin
      r_srdPrev   <= srd;
      r_swrPrev   <= swr;
      r_latchPrev <= gpio_latch;
    end
  end

  // Operand registers only accept writes while the engine is idle.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_a1 <= '0;
      r_a2 <= '0;
    end else begin
      if (w_wrA1 && !w_busy) r_a1 <= sdata_in[OP_W-1:0];
      if (w_wrA2 && !w_busy) r_a2 <= sdata_in[OP_W-1:0];
    end
  end

  // Done status is raised on the last popcount edge so it is visible in the
  // engine's DONE cycle; a fresh error outranks the clear-on-read.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_status  <= STAT_IDLE;
      r_err     <= 1'b0;
      r_opCount <= '0;
    end else begin
      if (w_start) begin
        r_status <= STAT_BUSY;
      end else if (w_finish) begin
        r_status <= w_overflow ? STAT_DONE_OVF : STAT_DONE;
      end
      if (w_busyWrite) begin
        r_err <= 1'b1;
      end else if (w_rdStatus) begin
        r_err <= 1'b0;
      end
      if (w_finish) r_opCount <= r_opCount + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sdataOut    <= '0;
      r_gpinLatched <= '0;
    end else begin
      if (w_rdEdge)    r_sdataOut    <= w_readData;
      if (w_latchEdge) r_gpinLatched <= gpio_in;
    end
  end

  assign sdata_out      = r_sdataOut;
  assign gpio_in_s_insp = r_gpinLatched;
  assign gpio_out       = 32'(r_opCount);

endmodule

// File: tb/tb_gpio_mulpop.sv
// Self-checking bench for gpio_mulpop: table vectors, randomized operands
// against an arithmetic reference, and hand-timed latency/busy/reset sequences.
module tb_gpio_mulpop;

  localparam logic [15:0] BASE     = 16'h0380;
  localparam logic [15:0] ADR_A1   = BASE + 16'h0000;
  localparam logic [15:0] ADR_A2   = BASE + 16'h0008;
  localparam logic [15:0] ADR_W    = BASE + 16'h0010;
  localparam logic [15:0] ADR_L    = BASE + 16'h0018;
  localparam logic [15:0] ADR_CTRL = BASE + 16'h0020;
  localparam logic [15:0] ADR_GPIN = BASE + 16'h0028;
  localparam logic [15:0] ADR_NONE = BASE + 16'h0030;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [15:0] saddress;
  logic        srd;
  logic        swr;
  logic [31:0] sdata_in;
  logic [31:0] sdata_out;
  logic [31:0] gpio_in;
  logic        gpio_latch;
  logic [31:0] gpio_in_s_insp;
  logic [31:0] gpio_out;
  logic [31:0] sdata_out2;
  logic [31:0] gpio_in_s_insp2;
  logic [31:0] gpio_out2;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int modelCount  = 0;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [31:0] expW;
    logic [31:0] expL;
    logic [31:0] expStatus;
  } vec_t;

  vec_t vecTable[6];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gpio_mulpop dut (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_in_s_insp (gpio_in_s_insp),
    .gpio_out       (gpio_out)
  );

  // Narrow-counter copy sharing the same bus stimulus, used for wrap checks.
  gpio_mulpop #(.CNT_W(2)) dut2 (
    .clk            (clk),
    .n_reset        (n_reset),
    .saddress       (saddress),
    .srd            (srd),
    .swr            (swr),
    .sdata_in       (sdata_in),
    .sdata_out      (sdata_out2),
    .gpio_in        (gpio_in),
    .gpio_latch     (gpio_latch),
    .gpio_in_s_insp (gpio_in_s_insp2),
    .gpio_out       (gpio_out2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitCycle(input int target);
    while (cyc < target) tick();
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pulseWrite(input logic [15:0] addr, input logic [31:0] data);
    saddress = addr;
    sdata_in = data;
    swr = 1'b1;
    tick();
    swr = 1'b0;
  endtask

  task automatic pulseRead(input logic [15:0] addr, output logic [31:0] data);
    saddress = addr;
    srd = 1'b1;
    tick();
    srd = 1'b0;
    data = sdata_out;
  endtask

  task automatic busWrite(input logic [15:0] addr, input logic [31:0] data);
    pulseWrite(addr, data);
    tick();
  endtask

  task automatic busRead(input logic [15:0] addr, output logic [31:0] data);
    pulseRead(addr, data);
    tick();
  endtask

  // Reference: plain 64-bit product, truncation, popcount and overflow test.
  function automatic void refModel(input logic [23:0] a, input logic [23:0] b,
                                   output logic [31:0] w, output logic [31:0] l,
                                   output logic [31:0] st);
    logic [63:0] p;
    p  = 64'(a) * 64'(b);
    w  = p[31:0];
    l  = 32'($countones(p[31:0]));
    st = ((p >> 32) != 64'd0) ? 32'h3 : 32'h2;
  endfunction

  task automatic startAndCheck(input string tag, input logic [31:0] expW,
                               input logic [31:0] expL, input logic [31:0] expSt);
    logic [31:0] s;
    logic [31:0] d;
    bit done;
    busWrite(ADR_CTRL, 32'h1);
    done = 0;
    s = '0;
    for (int i = 0; i < 100 && !done; i++) begin
      busRead(ADR_CTRL, s);
      if (s[1]) done = 1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s_timeout: status 0x%08h, expected done within budget", tag, s);
    end
    modelCount++;
    checkOutput({tag, "_status"}, s, expSt);
    busRead(ADR_W, d);
    checkOutput({tag, "_W"}, d, expW);
    busRead(ADR_L, d);
    checkOutput({tag, "_L"}, d, expL);
    checkOutput({tag, "_count"}, gpio_out, 32'(modelCount % 65536));
    checkOutput({tag, "_count2"}, gpio_out2, 32'(modelCount % 4));
  endtask

  task automatic applyStimulus(input string tag, input logic [23:0] a, input logic [23:0] b,
                               input logic [31:0] expW, input logic [31:0] expL,
                               input logic [31:0] expSt);
    busWrite(ADR_A1, 32'(a));
    busWrite(ADR_A2, 32'(b));
    startAndCheck(tag, expW, expL, expSt);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [31:0] mW;
    logic [31:0] mL;
    logic [31:0] mS;
    logic [23:0] ra;
    logic [23:0] rb;
    int t0;

    n_reset = 1'b0; srd = 1'b0; swr = 1'b0; saddress = '0;
    sdata_in = '0; gpio_in = '0; gpio_latch = 1'b0;

    vecTable[0] = '{24'd3,      24'd5,      32'd15,        32'd4,  32'h2};
    vecTable[1] = '{24'hFFFFFF, 24'hFFFFFF, 32'hFE000001,  32'd8,  32'h3};
    vecTable[2] = '{24'd0,      24'd123,    32'd0,         32'd0,  32'h2};
    vecTable[3] = '{24'd1,      24'hFFFFFF, 32'h00FFFFFF,  32'd24, 32'h2};
    vecTable[4] = '{24'h010000, 24'h010000, 32'h00000000,  32'd0,  32'h3};
    vecTable[5] = '{24'h00FFFF, 24'h010001, 32'hFFFFFFFF,  32'd32, 32'h2};

    repeat (3) tick();
    checkOutput("rst_sdata_out", sdata_out, 32'h0);
    checkOutput("rst_gpio_out", gpio_out, 32'h0);
    checkOutput("rst_insp", gpio_in_s_insp, 32'h0);
    n_reset = 1'b1;
    tick();
    busRead(ADR_CTRL, d);
    checkOutput("rst_status", d, 32'h0);
    busRead(ADR_W, d);
    checkOutput("rst_W", d, 32'h0);

    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("tbl%0d", i), vecTable[i].a, vecTable[i].b,
                    vecTable[i].expW, vecTable[i].expL, vecTable[i].expStatus);

    for (int i = 0; i < 8; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      refModel(ra, rb, mW, mL, mS);
      applyStimulus($sformatf("rnd%0d", i), ra, rb, mW, mL, mS);
    end

    // Latency A: W gated before done, STATUS busy at 56, held srd reads once.
    busWrite(ADR_A1, 32'd3);
    busWrite(ADR_A2, 32'd5);
    t0 = cyc;
    pulseWrite(ADR_CTRL, 32'h0);
    waitCycle(t0 + 20);
    pulseRead(ADR_W, d);
    checkOutput("lat_W_busy", d, 32'h0);
    waitCycle(t0 + 56);
    saddress = ADR_CTRL;
    srd = 1'b1;
    tick();
    checkOutput("lat_status56", sdata_out, 32'h1);
    repeat (3) tick();
    checkOutput("lat_held_srd", sdata_out, 32'h1);
    srd = 1'b0;
    tick();
    modelCount++;
    busRead(ADR_CTRL, d);
    checkOutput("lat_status_after", d, 32'h2);

    // Latency B: STATUS done from a read edge at 57; gpio_out moves with it.
    t0 = cyc;
    pulseWrite(ADR_CTRL, 32'h0);
    waitCycle(t0 + 56);
    checkOutput("latB_count56", gpio_out, 32'(modelCount));
    waitCycle(t0 + 57);
    modelCount++;
    checkOutput("latB_count57", gpio_out, 32'(modelCount));
    pulseRead(ADR_CTRL, d);
    checkOutput("latB_status57", d, 32'h2);
    tick();
    busRead(ADR_W, d);
    checkOutput("latB_W", d, 32'd15);

    // Start edge during the DONE cycle is a busy write, not a new operation.
    t0 = cyc;
    pulseWrite(ADR_CTRL, 32'h0);
    waitCycle(t0 + 57);
    pulseWrite(ADR_CTRL, 32'h0);
    modelCount++;
    tick();
    busRead(ADR_CTRL, d);
    checkOutput("doneStart_err", d, 32'h6);
    busRead(ADR_CTRL, d);
    checkOutput("doneStart_clr", d, 32'h2);
    waitCycle(t0 + 150);
    checkOutput("doneStart_noop", gpio_out, 32'(modelCount));

    // Busy writes to A1 and CTRL are rejected and flagged.
    refModel(24'h123456, 24'h000ABC, mW, mL, mS);
    busWrite(ADR_A1, 32'h00123456);
    busWrite(ADR_A2, 32'h00000ABC);
    t0 = cyc;
    pulseWrite(ADR_CTRL, 32'h0);
    waitCycle(t0 + 5);
    pulseWrite(ADR_A1, 32'd7);
    tick();
    pulseWrite(ADR_CTRL, 32'h0);
    waitCycle(t0 + 62);
    modelCount++;
    busRead(ADR_CTRL, d);
    checkOutput("busy_status_err", d, mS | 32'h4);
    busRead(ADR_CTRL, d);
    checkOutput("busy_status_clr", d, mS);
    busRead(ADR_W, d);
    checkOutput("busy_W", d, mW);
    startAndCheck("busy_rerun", mW, mL, mS);

    // GPIO latch path.
    gpio_in = 32'hA5A5A5A5;
    gpio_latch = 1'b1;
    tick();
    gpio_latch = 1'b0;
    checkOutput("gpio_insp", gpio_in_s_insp, 32'hA5A5A5A5);
    gpio_in = 32'h5A5A5A5A;
    repeat (2) tick();
    checkOutput("gpio_insp_hold", gpio_in_s_insp, 32'hA5A5A5A5);
    busRead(ADR_GPIN, d);
    checkOutput("gpio_gpin_read", d, 32'hA5A5A5A5);

    // Reset mid-MULT clears everything asynchronously.
    t0 = cyc;
    pulseWrite(ADR_CTRL, 32'h0);
    waitCycle(t0 + 10);
    n_reset = 1'b0;
    #1;
    checkOutput("midrst_sdata_out", sdata_out, 32'h0);
    checkOutput("midrst_gpio_out", gpio_out, 32'h0);
    checkOutput("midrst_insp", gpio_in_s_insp, 32'h0);
    checkOutput("midrst_gpio_out2", gpio_out2, 32'h0);
    modelCount = 0;
    repeat (2) tick();
    n_reset = 1'b1;
    tick();
    busRead(ADR_CTRL, d);
    checkOutput("midrst_status", d, 32'h0);
    busRead(ADR_W, d);
    checkOutput("midrst_W", d, 32'h0);

    // Four operations wrap the 2-bit counter back to zero.
    for (int i = 0; i < 4; i++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      refModel(ra, rb, mW, mL, mS);
      applyStimulus($sformatf("wrap%0d", i), ra, rb, mW, mL, mS);
    end
    checkOutput("wrap_cnt2_zero", gpio_out2, 32'h0);
    checkOutput("wrap_cnt16", gpio_out, 32'd4);

    busRead(ADR_NONE, d);
    checkOutput("unmapped_read", d, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
